// File: rtl/ping_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ping_scheduler
// Brief    : Round-robin trigger/echo ranging controller sharing one timer
//            across N ultrasonic sensors, with timeout and inter-ping guard.
// Revision : 1.0 - initial release
// ============================================================================
module ping_scheduler #(
    parameter int N_SENSORS      = 4,
    parameter int ID_W           = 2,
    parameter int TRIG_CYCLES    = 500,
    parameter int TIMEOUT_CYCLES = 1500000,
    parameter int GUARD_CYCLES   = 3000000,
    parameter int COUNT_W        = 22
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [N_SENSORS-1:0] echo,
    output logic [N_SENSORS-1:0] trig,
    output logic                 busy,
    output logic [ID_W-1:0]      cur_id,
    output logic                 sample_valid,
    output logic [ID_W-1:0]      sample_id,
    output logic [COUNT_W-1:0]   sample_width,
    output logic                 sample_timeout
);

    // The shared counter must also span the guard interval, which may exceed COUNT_W.
    localparam int c_GUARD_W = $clog2(GUARD_CYCLES + 1);
    localparam int c_CNT_W   = (c_GUARD_W > COUNT_W) ? c_GUARD_W : COUNT_W;

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_TRIG      = 3'd1;
    localparam logic [2:0] c_WAIT_RISE = 3'd2;
    localparam logic [2:0] c_MEASURE   = 3'd3;
    localparam logic [2:0] c_GUARD     = 3'd4;

    localparam logic [c_CNT_W-1:0] c_CNT_ONE      = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_TRIG_LAST    = c_CNT_W'(TRIG_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_GUARD_LAST   = c_CNT_W'(GUARD_CYCLES - 1);
    localparam logic [COUNT_W-1:0] c_TIMEOUT_W    = COUNT_W'(TIMEOUT_CYCLES);
    localparam logic [ID_W-1:0]    c_ID_ONE       = ID_W'(1);
    localparam logic [ID_W-1:0]    c_LAST_ID      = ID_W'(N_SENSORS - 1);

    logic [2:0]           r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [ID_W-1:0]      r_cur_id;
    logic [N_SENSORS-1:0] r_echo_meta;
    logic [N_SENSORS-1:0] r_echo_sync;
    logic [N_SENSORS-1:0] r_echo_prev;
    logic                 r_sample_valid;
    logic [ID_W-1:0]      r_sample_id;
    logic [COUNT_W-1:0]   r_sample_width;
    logic                 r_sample_timeout;

    logic                 w_echo_cur;
    logic                 w_echo_prev;
    logic                 w_rise;
    logic                 w_emit;
    logic [COUNT_W-1:0]   w_emit_width;
    logic                 w_emit_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_echo_meta <= '0;
            r_echo_sync <= '0;
            r_echo_prev <= '0;
        end else begin
            r_echo_meta <= echo;
            r_echo_sync <= r_echo_meta;
            r_echo_prev <= r_echo_sync;
        end
    end

    assign w_echo_cur  = r_echo_sync[r_cur_id];
    assign w_echo_prev = r_echo_prev[r_cur_id];
    assign w_rise      = w_echo_cur && !w_echo_prev;

    always_comb begin
        w_emit         = 1'b0;
        w_emit_width   = '0;
        w_emit_timeout = 1'b0;
        case (r_state)
            c_WAIT_RISE: begin
                if (!w_rise && (r_cnt == c_TIMEOUT_LAST)) begin
                    w_emit         = 1'b1;
                    w_emit_timeout = 1'b1;
                end
            end
            c_MEASURE: begin
                if (!w_echo_cur) begin
                    w_emit       = 1'b1;
                    w_emit_width = r_cnt[COUNT_W-1:0];
                end else if (r_cnt == c_TIMEOUT_LAST) begin
                    // This high cycle would be the TIMEOUT_CYCLES-th: saturate.
                    w_emit         = 1'b1;
                    w_emit_width   = c_TIMEOUT_W;
                    w_emit_timeout = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_cnt    <= '0;
            r_cur_id <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (enable) begin
                        r_state <= c_TRIG;
                        r_cnt   <= '0;
                    end
                end
                c_TRIG: begin
                    if (r_cnt == c_TRIG_LAST) begin
                        r_state <= c_WAIT_RISE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                c_WAIT_RISE: begin
                    // The edge cycle itself is the first counted high cycle.
                    if (w_rise) begin
                        r_state <= c_MEASURE;
                        r_cnt   <= c_CNT_ONE;
                    end else if (w_emit) begin
                        r_state <= c_GUARD;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                c_MEASURE: begin
                    if (w_emit) begin
                        r_state <= c_GUARD;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                c_GUARD: begin
                    if (r_cnt == c_GUARD_LAST) begin
                        r_cur_id <= (r_cur_id == c_LAST_ID) ? '0 : r_cur_id + c_ID_ONE;
                        r_state  <= enable ? c_TRIG : c_IDLE;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sample_valid   <= 1'b0;
            r_sample_id      <= '0;
            r_sample_width   <= '0;
            r_sample_timeout <= 1'b0;
        end else begin
            r_sample_valid <= w_emit;
            if (w_emit) begin
                r_sample_id      <= r_cur_id;
                r_sample_width   <= w_emit_width;
                r_sample_timeout <= w_emit_timeout;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_SENSORS; gi++) begin : g_trig
            assign trig[gi] = (r_state == c_TRIG) && (r_cur_id == ID_W'(gi));
        end
    endgenerate

    assign busy           = (r_state != c_IDLE);
    assign cur_id         = r_cur_id;
    assign sample_valid   = r_sample_valid;
    assign sample_id      = r_sample_id;
    assign sample_width   = r_sample_width;
    assign sample_timeout = r_sample_timeout;

endmodule
`default_nettype wire
